// File: rtl/spi_flash_read_sequencer_if.sv
// Bus bundle between the flash read sequencer and its neighbours.
// Carries the command handshake (cmd_*), the read-data stream (rd_*), the
// completion pulse, the flash chip select and the byte-controller handshake
// (spi_*). Modport 'master' is the sequencer side, 'slave' is the
// host + byte-controller side.
interface spi_flash_read_sequencer_if #(
  parameter int unsigned LEN_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [23:0]      cmd_addr;
  logic [LEN_W-1:0] cmd_len;
  logic [7:0]       rd_data;
  logic             rd_valid;
  logic             rd_ready;
  logic             done;
  logic             flash_cs_n;
  logic             spi_start;
  logic [7:0]       spi_data_in;
  logic             spi_busy;
  logic [7:0]       spi_data_out;

  modport master (
    input  cmd_valid, cmd_addr, cmd_len, rd_ready, spi_busy, spi_data_out,
    output cmd_ready, rd_data, rd_valid, done, flash_cs_n, spi_start, spi_data_in
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_len, rd_ready, spi_busy, spi_data_out,
    input  cmd_ready, rd_data, rd_valid, done, flash_cs_n, spi_start, spi_data_in
  );
endinterface

// File: rtl/spi_flash_read_sequencer.sv
// Sequences SPI-flash READ transactions (opcode, 24-bit address, N data
// bytes) on top of a single-byte SPI master. Holds its own chip select low
// across the whole transaction and streams data bytes out with valid/ready.
// Ports:
//   clk_i  - system clock
//   rst_ni - asynchronous active-low reset
//   bus    - command, read-data, done, flash_cs_n and byte-controller signals
module spi_flash_read_sequencer #(
  parameter logic [7:0]  READ_OPCODE  = 8'h03,
  parameter int unsigned LEN_W        = 8,
  parameter int unsigned CS_SETUP_CYC = 2,
  parameter int unsigned CS_HOLD_CYC  = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  spi_flash_read_sequencer_if.master    bus
);

  // Byte index is one bit wider than len so 4+len never wraps.
  localparam int unsigned IDX_W   = LEN_W + 1;
  localparam int unsigned CNT_MAX = (CS_SETUP_CYC > CS_HOLD_CYC) ? CS_SETUP_CYC : CS_HOLD_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE, SETUP, ISSUE, WAIT_ACCEPT, WAIT_DONE, OUTPUT, HOLD
  } state_e;

  state_e           state_q, state_d;
  logic [23:0]      addr_q, addr_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             rd_valid_q, rd_valid_d;
  logic [7:0]       rd_data_q, rd_data_d;
  logic             done_q, done_d;
  logic             cs_n_q, cs_n_d;
  logic             start_q, start_d;
  logic [7:0]       sdi_q, sdi_d;

  logic [IDX_W-1:0] idx_inc_c;
  logic [IDX_W-1:0] byte_end_c;
  logic [7:0]       byte_sel_c;
  logic             finish_c;

  assign idx_inc_c  = idx_q + IDX_W'(1);
  assign byte_end_c = IDX_W'(len_q) + IDX_W'(4);

  // Byte to transmit for the current index: opcode, address MSB first, then dummies.
  always_comb begin
    byte_sel_c = 8'h00;
    case (idx_q)
      IDX_W'(0): byte_sel_c = READ_OPCODE;
      IDX_W'(1): byte_sel_c = addr_q[23:16];
      IDX_W'(2): byte_sel_c = addr_q[15:8];
      IDX_W'(3): byte_sel_c = addr_q[7:0];
      default:   byte_sel_c = 8'h00;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    cmd_ready_d = cmd_ready_q;
    rd_valid_d  = rd_valid_q;
    rd_data_d   = rd_data_q;
    done_d      = 1'b0;
    cs_n_d      = cs_n_q;
    start_d     = start_q;
    sdi_d       = sdi_q;
    finish_c    = 1'b0;

    case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        // Accept only once cmd_ready is visible, so a command held through reset waits a cycle.
        if (bus.cmd_valid && cmd_ready_q) begin
          addr_d      = bus.cmd_addr;
          len_d       = bus.cmd_len;
          idx_d       = '0;
          cnt_d       = '0;
          cs_n_d      = 1'b0;
          cmd_ready_d = 1'b0;
          state_d     = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == CNT_W'(CS_SETUP_CYC - 1)) state_d = ISSUE;
        else                                   cnt_d   = cnt_q + CNT_W'(1);
      end
      ISSUE: begin
        sdi_d   = byte_sel_c;
        start_d = 1'b1;
        state_d = WAIT_ACCEPT;
      end
      WAIT_ACCEPT: begin
        // The byte controller samples start only on SCK ticks; hold until it reports busy.
        if (bus.spi_busy) begin
          start_d = 1'b0;
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (!bus.spi_busy) begin
          idx_d = idx_inc_c;
          if (idx_q >= IDX_W'(4)) begin
            rd_data_d  = bus.spi_data_out;
            rd_valid_d = 1'b1;
            state_d    = OUTPUT;
          end else if (idx_inc_c == byte_end_c) begin
            finish_c = 1'b1;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      OUTPUT: begin
        // idx_q was already advanced when this byte completed.
        if (bus.rd_ready) begin
          rd_valid_d = 1'b0;
          if (idx_q == byte_end_c) finish_c = 1'b1;
          else                     state_d  = ISSUE;
        end
      end
      HOLD: begin
        if (cnt_q == CNT_W'(CS_HOLD_CYC - 1)) begin
          state_d     = IDLE;
          cmd_ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (finish_c) begin
      cs_n_d  = 1'b1;
      done_d  = 1'b1;
      cnt_d   = '0;
      state_d = HOLD;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= 8'h00;
      done_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      start_q     <= 1'b0;
      sdi_q       <= 8'h00;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      cmd_ready_q <= cmd_ready_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      done_q      <= done_d;
      cs_n_q      <= cs_n_d;
      start_q     <= start_d;
      sdi_q       <= sdi_d;
    end
  end

  assign bus.cmd_ready   = cmd_ready_q;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.rd_data     = rd_data_q;
  assign bus.done        = done_q;
  assign bus.flash_cs_n  = cs_n_q;
  assign bus.spi_start   = start_q;
  assign bus.spi_data_in = sdi_q;

endmodule

// File: tb/tb_spi_flash_read_sequencer.sv
// Directed bench for spi_flash_read_sequencer with a behavioural byte controller.
module tb_spi_flash_read_sequencer;

  localparam int unsigned CS_HOLD = 4;

  logic clk = 1'b0;
  logic rst_n;

  spi_flash_read_sequencer_if #(.LEN_W(8)) bus ();

  spi_flash_read_sequencer #(
    .READ_OPCODE (8'h03),
    .LEN_W       (8),
    .CS_SETUP_CYC(2),
    .CS_HOLD_CYC (CS_HOLD)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Byte controller model: latch start, busy after 2 cycles, busy for 4 cycles.
  logic [7:0] tbl [0:3];
  logic [7:0] sent_q [$];
  int         m_state;
  int         m_cnt;
  int         byte_cnt;
  logic       m_busy;
  logic [7:0] m_dout;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state  <= 0;
      m_cnt    <= 0;
      byte_cnt <= 0;
      m_busy   <= 1'b0;
      m_dout   <= 8'h00;
    end else begin
      if (bus.flash_cs_n) byte_cnt <= 0;
      case (m_state)
        0: if (bus.spi_start) begin
             sent_q.push_back(bus.spi_data_in);
             m_state <= 1;
             m_cnt   <= 0;
           end
        1: if (m_cnt == 1) begin
             m_busy  <= 1'b1;
             m_state <= 2;
             m_cnt   <= 0;
           end else m_cnt <= m_cnt + 1;
        default: if (m_cnt == 3) begin
             m_busy   <= 1'b0;
             m_dout   <= (byte_cnt >= 4) ? tbl[2'(byte_cnt - 4)] : 8'hEE;
             byte_cnt <= byte_cnt + 1;
             m_state  <= 0;
           end else m_cnt <= m_cnt + 1;
      endcase
    end
  end

  assign bus.spi_busy     = m_busy;
  assign bus.spi_data_out = m_dout;

  // Monitors: accepted read bytes, done pulses, rd_valid cycles, chip-select rises.
  logic [7:0] rd_q [$];
  int done_cnt = 0;
  int rdv_cnt  = 0;
  int cs_rise  = 0;
  int cs_bad   = 0;
  logic cs_prev = 1'b1;

  always @(posedge clk) begin
    if (rst_n) begin
      if (bus.rd_valid && bus.rd_ready) rd_q.push_back(bus.rd_data);
      if (bus.done)     done_cnt <= done_cnt + 1;
      if (bus.rd_valid) rdv_cnt  <= rdv_cnt + 1;
      if (!cs_prev && bus.flash_cs_n) begin
        cs_rise <= cs_rise + 1;
        if (!bus.done) cs_bad <= cs_bad + 1;
      end
    end
    cs_prev <= bus.flash_cs_n;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_q(input string tag, input logic [7:0] q[$], input int base,
                       input logic [7:0] e[$]);
    chk({tag, "_count"}, 32'(q.size() - base), 32'(e.size()));
    for (int i = 0; i < e.size(); i++)
      if (base + i < q.size())
        chk($sformatf("%s_%0d", tag, i), 32'(q[base + i]), 32'(e[i]));
  endtask

  task automatic issue_cmd(input logic [23:0] a, input logic [7:0] l);
    int k;
    @(negedge clk);
    bus.cmd_addr  = a;
    bus.cmd_len   = l;
    bus.cmd_valid = 1'b1;
    k = 0;
    while (!bus.cmd_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("accept_timeout", 32'(bus.cmd_ready), 32'd1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (!bus.done && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 32'(bus.done), 32'd1);
  endtask

  initial begin
    logic [7:0] e[$];
    int s0, r0, d0, v0, c0, b0, k, gap;
    logic ok;

    // Reset held low with a pending command.
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = 24'h0;
    bus.cmd_len   = 8'h0;
    bus.rd_ready  = 1'b1;
    tbl[0] = 8'hA5; tbl[1] = 8'h5A; tbl[2] = 8'h00; tbl[3] = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_cs_n",      32'(bus.flash_cs_n), 32'd1);
    chk("rst_spi_start", 32'(bus.spi_start),  32'd0);
    chk("rst_cmd_ready", 32'(bus.cmd_ready),  32'd0);
    chk("rst_rd_valid",  32'(bus.rd_valid),   32'd0);
    chk("rst_done",      32'(bus.done),       32'd0);
    rst_n         = 1'b1;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("cmd_ready_after_rst", 32'(bus.cmd_ready), 32'd1);

    // Basic READ, len=2, no backpressure.
    s0 = sent_q.size(); r0 = rd_q.size(); d0 = done_cnt; c0 = cs_rise; b0 = cs_bad;
    issue_cmd(24'h123456, 8'd2);
    wait_done("t1_done_timeout");
    @(negedge clk);
    e = {8'h03, 8'h12, 8'h34, 8'h56, 8'h00, 8'h00};
    chk_q("t1_mosi", sent_q, s0, e);
    e = {8'hA5, 8'h5A};
    chk_q("t1_rd", rd_q, r0, e);
    chk("t1_done_pulses", 32'(done_cnt - d0), 32'd1);
    chk("t1_cs_rises",    32'(cs_rise - c0),  32'd1);
    chk("t1_cs_early",    32'(cs_bad - b0),   32'd0);

    // Same command with the first data byte held off for 50 cycles.
    s0 = sent_q.size(); r0 = rd_q.size(); d0 = done_cnt;
    bus.rd_ready = 1'b0;
    issue_cmd(24'h123456, 8'd2);
    k = 0;
    while (!bus.rd_valid && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("t2_rd_valid_timeout", 32'(bus.rd_valid), 32'd1);
    ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (!(bus.rd_valid === 1'b1 && bus.rd_data === 8'hA5 && bus.flash_cs_n === 1'b0 &&
            bus.spi_start === 1'b0 && sent_q.size() == s0 + 5)) ok = 1'b0;
      @(negedge clk);
    end
    chk("t2_stall_held", 32'(ok), 32'd1);
    chk("t2_rd_data",    32'(bus.rd_data), 32'hA5);
    bus.rd_ready = 1'b1;
    wait_done("t2_done_timeout");
    @(negedge clk);
    e = {8'h03, 8'h12, 8'h34, 8'h56, 8'h00, 8'h00};
    chk_q("t2_mosi", sent_q, s0, e);
    e = {8'hA5, 8'h5A};
    chk_q("t2_rd", rd_q, r0, e);
    chk("t2_done_pulses", 32'(done_cnt - d0), 32'd1);

    // Header-only command.
    s0 = sent_q.size(); v0 = rdv_cnt; d0 = done_cnt;
    issue_cmd(24'h000000, 8'd0);
    wait_done("t3_done_timeout");
    k = 0;
    while (!bus.cmd_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("t3_hold_cycles", 32'(k), 32'(CS_HOLD));
    e = {8'h03, 8'h00, 8'h00, 8'h00};
    chk_q("t3_mosi", sent_q, s0, e);
    chk("t3_rd_valid_cycles", 32'(rdv_cnt - v0),  32'd0);
    chk("t3_done_pulses",     32'(done_cnt - d0), 32'd1);

    // Back-to-back: cmd_valid held across two transactions.
    s0 = sent_q.size(); r0 = rd_q.size(); d0 = done_cnt;
    tbl[0] = 8'h77;
    @(negedge clk);
    bus.cmd_addr  = 24'h00ABCD;
    bus.cmd_len   = 8'd1;
    bus.cmd_valid = 1'b1;
    wait_done("t4_done1_timeout");
    gap = 0;
    while (bus.flash_cs_n && gap < 100) begin
      gap++;
      @(negedge clk);
    end
    bus.cmd_valid = 1'b0;
    chk("t4_cs_high_gap", 32'(gap), 32'(CS_HOLD + 1));
    @(negedge clk);
    wait_done("t4_done2_timeout");
    @(negedge clk);
    e = {8'h03, 8'h00, 8'hAB, 8'hCD, 8'h00, 8'h03, 8'h00, 8'hAB, 8'hCD, 8'h00};
    chk_q("t4_mosi", sent_q, s0, e);
    e = {8'h77, 8'h77};
    chk_q("t4_rd", rd_q, r0, e);
    chk("t4_done_pulses", 32'(done_cnt - d0), 32'd2);

    // Reset while the second address byte is being offered.
    issue_cmd(24'hABCDEF, 8'd3);
    k = 0;
    while (!(bus.spi_start && bus.spi_data_in == 8'hCD) && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("t5_reach_addr1", 32'(bus.spi_data_in), 32'hCD);
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_cs_n",      32'(bus.flash_cs_n), 32'd1);
    chk("t5_rst_spi_start", 32'(bus.spi_start),  32'd0);
    chk("t5_rst_rd_valid",  32'(bus.rd_valid),   32'd0);
    repeat (3) @(negedge clk);
    chk("t5_rst_done", 32'(done_cnt - d0), 32'd0);
    rst_n = 1'b1;
    s0 = sent_q.size(); r0 = rd_q.size(); d0 = done_cnt;
    tbl[0] = 8'h3C;
    issue_cmd(24'h000010, 8'd1);
    wait_done("t5_done_timeout");
    @(negedge clk);
    e = {8'h03, 8'h00, 8'h00, 8'h10, 8'h00};
    chk_q("t5_mosi", sent_q, s0, e);
    e = {8'h3C};
    chk_q("t5_rd", rd_q, r0, e);
    chk("t5_done_pulses", 32'(done_cnt - d0), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
